// File: rtl/pool_pkg.sv
// Shared types and constants for the pool-unit bus arbiter.
package pool_pkg;

  localparam int unsigned DEF_ID_W  = 4;
  localparam int unsigned DEF_LEN_W = 4;

  // Round-robin flag encoding: which master was granted last.
  localparam logic RR_RD = 1'b0;
  localparam logic RR_WR = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_DATA
  } pool_arb_state_t;

endpackage

// File: rtl/pool_arb_wdog.sv
// Grant watchdog: counts cycles in the current state and flags expiry at TIMEOUT-1.
module pool_arb_wdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (run && !expire) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire = (cnt_q == LIMIT);

endmodule

// File: rtl/pool_bus_arb.sv
// Read/write channel arbiter for the pool-unit bus port with ID tracking,
// burst-length checking and a hung-slave watchdog.
module pool_bus_arb
  import pool_pkg::*;
#(
  parameter int unsigned ID_W    = DEF_ID_W,
  parameter int unsigned LEN_W   = DEF_LEN_W,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_req,
  input  logic [ID_W-1:0]  rd_id,
  input  logic [LEN_W-1:0] rd_len,
  input  logic             wr_req,
  input  logic [ID_W-1:0]  wr_id,
  input  logic [LEN_W-1:0] wr_len,
  input  logic             arready,
  input  logic             awready,
  input  logic             rvalid,
  input  logic             rlast,
  input  logic [ID_W-1:0]  rid,
  input  logic             wready,
  input  logic             wuser_last,
  input  logic [ID_W-1:0]  wuser_id,
  output logic             link_read,
  output logic             link_write,
  output logic             grant_wr,
  output logic             busy,
  output logic             err_len,
  output logic             err_timeout
);

  pool_arb_state_t  state_q, state_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W:0]   beats_q, beats_d, beats_inc, len_ext;
  logic             last_wr_q, last_wr_d;
  logic             err_len_d, err_to_d;
  logic             pick_wr, beat_hit, beat_last;
  logic             wdog_expire, expire;

  pool_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_d != state_q),
    .run    (state_q != IDLE),
    .expire (wdog_expire)
  );

  assign expire    = wdog_expire && (state_q != IDLE);
  assign beats_inc = (beats_q == '1) ? beats_q : beats_q + 1'b1;
  assign len_ext   = {1'b0, len_q} + 1'b1;

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    len_d     = len_q;
    beats_d   = beats_q;
    last_wr_d = last_wr_q;
    err_len_d = err_len;
    err_to_d  = err_timeout;
    pick_wr   = 1'b0;
    beat_hit  = 1'b0;
    beat_last = 1'b0;

    if (expire) begin
      state_d  = IDLE;
      err_to_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rd_req || wr_req) begin
            pick_wr   = wr_req && (!rd_req || (last_wr_q == RR_RD));
            state_d   = pick_wr ? WR_ADDR : RD_ADDR;
            id_d      = pick_wr ? wr_id : rd_id;
            len_d     = pick_wr ? wr_len : rd_len;
            beats_d   = '0;
            last_wr_d = pick_wr ? RR_WR : RR_RD;
          end
        end
        RD_ADDR: if (arready && rd_req) state_d = RD_DATA;
        WR_ADDR: if (awready && wr_req) state_d = WR_DATA;
        RD_DATA: begin
          beat_hit  = rvalid && (rid == id_q);
          beat_last = beat_hit && rlast;
        end
        WR_DATA: begin
          beat_hit  = wready && (wuser_id == id_q);
          beat_last = beat_hit && wuser_last;
        end
        default: state_d = IDLE;
      endcase

      if (beat_hit) beats_d = beats_inc;
      if (beat_last) begin
        state_d = IDLE;
        if (beats_inc != len_ext) err_len_d = 1'b1;
      end
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      id_q        <= '0;
      len_q       <= '0;
      beats_q     <= '0;
      last_wr_q   <= RR_RD;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      busy        <= 1'b0;
      link_read   <= 1'b0;
      link_write  <= 1'b0;
      grant_wr    <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      len_q       <= len_d;
      beats_q     <= beats_d;
      last_wr_q   <= last_wr_d;
      err_len     <= err_len_d;
      err_timeout <= err_to_d;
      busy        <= (state_d != IDLE);
      link_read   <= (state_d != IDLE);
      link_write  <= (state_d != IDLE) && (state_d != RD_DATA);
      grant_wr    <= (state_d == WR_ADDR) || (state_d == WR_DATA);
    end
  end

endmodule

// File: tb/tb_pool_bus_arb.sv
// Randomized and directed check of pool_bus_arb against a transaction-level model.
module tb_pool_bus_arb;

  localparam int ID_W     = 4;
  localparam int LEN_W    = 4;
  localparam int TO       = 16;
  localparam int BEAT_MAX = (1 << (LEN_W + 1)) - 1;

  logic clk, rst;
  logic rd_req, wr_req, arready, awready, rvalid, rlast, wready, wuser_last;
  logic [ID_W-1:0]  rd_id, wr_id, rid, wuser_id;
  logic [LEN_W-1:0] rd_len, wr_len;
  logic link_read, link_write, grant_wr, busy, err_len, err_timeout;

  int total = 0;
  int bad   = 0;
  bit mon_on = 0;

  pool_bus_arb #(.ID_W(ID_W), .LEN_W(LEN_W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_id(rd_id), .rd_len(rd_len),
    .wr_req(wr_req), .wr_id(wr_id), .wr_len(wr_len),
    .arready(arready), .awready(awready),
    .rvalid(rvalid), .rlast(rlast), .rid(rid),
    .wready(wready), .wuser_last(wuser_last), .wuser_id(wuser_id),
    .link_read(link_read), .link_write(link_write), .grant_wr(grant_wr),
    .busy(busy), .err_len(err_len), .err_timeout(err_timeout)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Transaction-level model: phase 0 idle, 1 address, 2 data.
  int m_phase, m_wr, m_id, m_len, m_beats, m_age, m_last_wr, m_err_len, m_err_to;

  initial begin
    m_phase = 0; m_wr = 0; m_id = 0; m_len = 0; m_beats = 0;
    m_age = 0; m_last_wr = 0; m_err_len = 0; m_err_to = 0;
  end

  always @(posedge clk) begin
    int hit, last;
    if (rst) begin
      m_phase = 0; m_wr = 0; m_id = 0; m_len = 0; m_beats = 0;
      m_age = 0; m_last_wr = 0; m_err_len = 0; m_err_to = 0;
    end else if (m_phase != 0 && m_age == TO - 1) begin
      m_phase = 0; m_age = 0; m_err_to = 1;
    end else if (m_phase == 0) begin
      if (rd_req || wr_req) begin
        m_wr = (wr_req && (!rd_req || m_last_wr == 0)) ? 1 : 0;
        m_id = m_wr ? int'(wr_id) : int'(rd_id);
        m_len = m_wr ? int'(wr_len) : int'(rd_len);
        m_beats = 0; m_last_wr = m_wr; m_phase = 1; m_age = 0;
      end
    end else if (m_phase == 1) begin
      if (m_wr ? (awready && wr_req) : (arready && rd_req)) begin
        m_phase = 2; m_age = 0;
      end else m_age++;
    end else begin
      hit  = m_wr ? int'(wready && int'(wuser_id) == m_id) : int'(rvalid && int'(rid) == m_id);
      last = hit != 0 && (m_wr ? wuser_last : rlast);
      if (hit != 0 && m_beats < BEAT_MAX) m_beats++;
      if (last != 0) begin
        if (m_beats != m_len + 1) m_err_len = 1;
        m_phase = 0; m_age = 0;
      end else m_age++;
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      chk("m_busy", busy, m_phase != 0);
      chk("m_link_read", link_read, m_phase != 0);
      chk("m_link_write", link_write, m_phase != 0 && !(m_phase == 2 && m_wr == 0));
      chk("m_err_len", err_len, m_err_len);
      chk("m_err_timeout", err_timeout, m_err_to);
      if (m_phase != 0) chk("m_grant_wr", grant_wr, m_wr);
    end
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic idle_in();
    rd_req = 0; wr_req = 0; arready = 0; awready = 0;
    rvalid = 0; rlast = 0; wready = 0; wuser_last = 0;
    rd_id = '0; wr_id = '0; rd_len = '0; wr_len = '0; rid = '0; wuser_id = '0;
  endtask

  task automatic do_reset();
    rst = 1; nxt(); rst = 0;
  endtask

  initial begin
    int n;
    bit [3:0] ids [3];
    bit lasts [3];
    bit busys [3];
    rst = 1;
    idle_in();
    repeat (2) @(posedge clk);
    nxt();
    rst = 0;
    mon_on = 1;
    chk("rst_busy", busy, 0);
    chk("rst_links", {link_read, link_write}, 0);
    chk("rst_errs", {err_len, err_timeout}, 0);

    // Single read, id 3, len 3.
    rd_req = 1; rd_id = 3; rd_len = 3; nxt();
    chk("rd_grant_busy", busy, 1);
    chk("rd_addr_links", {link_read, link_write}, 3);
    chk("rd_grant_wr", grant_wr, 0);
    nxt();
    arready = 1; nxt();
    chk("rd_data_links", {link_read, link_write}, 2);
    arready = 0; rd_req = 0;
    for (int i = 0; i < 4; i++) begin
      rvalid = 1; rid = 3; rlast = (i == 3); nxt();
      chk("rd_beat_busy", busy, (i == 3) ? 0 : 1);
    end
    idle_in();
    chk("rd_err_len", err_len, 0);
    chk("rd_end_links", {link_read, link_write}, 0);

    // Round-robin under continuous conflict.
    do_reset();
    rd_req = 1; wr_req = 1; rd_id = 1; wr_id = 2;
    for (int r = 0; r < 4; r++) begin
      nxt();
      chk("rr_grant_wr", grant_wr, (r % 2 == 0) ? 1 : 0);
      chk("rr_busy", busy, 1);
      if (r % 2 == 0) awready = 1; else arready = 1;
      nxt();
      awready = 0; arready = 0;
      if (r % 2 == 0) begin wready = 1; wuser_id = 2; wuser_last = 1; end
      else begin rvalid = 1; rid = 1; rlast = 1; end
      nxt();
      wready = 0; wuser_last = 0; rvalid = 0; rlast = 0;
      chk("rr_end_busy", busy, 0);
      if (r == 3) begin rd_req = 0; wr_req = 0; end
    end
    idle_in();

    // Write len 1 with a foreign-ID beat carrying wuser_last.
    ids = '{4'd2, 4'd5, 4'd2}; lasts = '{0, 1, 1}; busys = '{1, 1, 0};
    wr_req = 1; wr_id = 2; wr_len = 1; nxt();
    chk("wr_grant_wr", grant_wr, 1);
    awready = 1; nxt();
    awready = 0; wr_req = 0;
    for (int i = 0; i < 3; i++) begin
      wready = 1; wuser_id = ids[i]; wuser_last = lasts[i]; nxt();
      chk("wr_beat_busy", busy, busys[i]);
    end
    idle_in();
    chk("wr_err_len", err_len, 0);

    // Short read burst, then a good one: err_len sticks.
    rd_req = 1; rd_id = 1; rd_len = 3; nxt();
    arready = 1; nxt();
    arready = 0; rd_req = 0; rvalid = 1; rid = 1; nxt();
    rlast = 1; nxt();
    idle_in();
    chk("short_busy", busy, 0);
    chk("short_err_len", err_len, 1);
    rd_req = 1; rd_id = 4; rd_len = 0; nxt();
    arready = 1; nxt();
    arready = 0; rd_req = 0; rvalid = 1; rid = 4; rlast = 1; nxt();
    idle_in();
    chk("good_busy", busy, 0);
    chk("sticky_err_len", err_len, 1);

    // Watchdog: arready never comes.
    rd_req = 1; rd_id = 0; nxt();
    rd_req = 0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (!busy) break;
      n++;
      nxt();
    end
    chk("to_busy_cycles", n, TO);
    chk("to_err_timeout", err_timeout, 1);
    chk("to_links", {link_read, link_write}, 0);
    chk("to_err_len_kept", err_len, 1);

    // Reset during WR_DATA, then a fresh read.
    wr_req = 1; wr_id = 6; wr_len = 2; nxt();
    awready = 1; nxt();
    awready = 0; wready = 1; wuser_id = 6; nxt();
    chk("wd_busy", busy, 1);
    idle_in(); rst = 1; nxt();
    rst = 0;
    chk("mid_rst_outs", {busy, link_read, link_write, grant_wr, err_len, err_timeout}, 0);
    rd_req = 1; rd_id = 7; nxt();
    chk("post_rst_busy", busy, 1);
    chk("post_rst_grant_wr", grant_wr, 0);
    idle_in();

    // Randomized traffic checked by the model on every cycle.
    for (int c = 0; c < 4000; c++) begin
      rst        = ($urandom_range(0, 299) == 0);
      rd_req     = $urandom_range(0, 1);
      wr_req     = $urandom_range(0, 1);
      rd_id      = 4'($urandom_range(0, 3));
      wr_id      = 4'($urandom_range(0, 3));
      rd_len     = 4'($urandom_range(0, 3));
      wr_len     = 4'($urandom_range(0, 3));
      arready    = ($urandom_range(0, 2) == 0);
      awready    = ($urandom_range(0, 2) == 0);
      rvalid     = $urandom_range(0, 1);
      wready     = $urandom_range(0, 1);
      rid        = ($urandom_range(0, 3) != 0) ? 4'(m_id) : 4'($urandom);
      wuser_id   = ($urandom_range(0, 3) != 0) ? 4'(m_id) : 4'($urandom);
      rlast      = ($urandom_range(0, 3) == 0);
      wuser_last = ($urandom_range(0, 3) == 0);
      nxt();
    end
    rst = 0;
    idle_in();
    nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
